alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational 2-bit ALU slice (A, B, 3-bit OP in; out, c, z back) between NREQ requesters.
- Round-robin arbitration; valid/ready handshake on every requester port.
- Each accepted operation is issued to the ALU, and its result is captured into a single registered response channel tagged with the requester index.
- Sits between the ALU slice and the sequencing logic that issues ALU operations.

Parameters:
- NREQ, 4, number of requesters (legal 2..8)
- IDW, 3, width of rsp_id; must satisfy 2**IDW >= NREQ

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; one-hot or zero
- req_op  input  3*NREQ  opcode for requester i in bits [3i+2:3i]
- req_a  input  2*NREQ  operand A for requester i in bits [2i+1:2i]
- req_b  input  2*NREQ  operand B, same packing as req_a
- alu_op  output  3  opcode to shared ALU
- alu_a  output  2  operand A to shared ALU
- alu_b  output  2  operand B to shared ALU
- alu_out  input  2  ALU result (combinational from alu_*)
- alu_c  input  1  ALU carry/borrow flag
- alu_z  input  1  ALU zero flag
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  IDW  index of requester that owns the response
- rsp_out  output  2  captured ALU result
- rsp_c  output  1  captured carry/borrow
- rsp_z  output  1  captured zero flag
- stat_grants  output  8*NREQ  per-requester grant counters (see Optional Feature)

Behaviour:
- Reset: one clock, synchronous, active-high (rst); polarity and synchronicity fixed.
- Reset values: rsp_valid=0, rsp_id=0, rsp_out=0, rsp_c=0, rsp_z=0, stat_grants=0. The round-robin pointer last_grant resets to NREQ-1, so requester 0 has first priority.
- FSM, 2 states:
  - EMPTY: response register free.
  - FULL: holds an undelivered response.
- can_issue = (state==EMPTY) | (rsp_valid & rsp_ready).
- Grant (combinational):
  - When can_issue, search req_valid starting at (last_grant+1) mod NREQ, wrapping; the first set bit wins.
  - req_ready = one-hot of the winner; all zero when no request or when !can_issue.
- ALU drive:
  - With a grant, alu_op/alu_a/alu_b = the winner's fields.
  - Without a grant, alu_op=3'b000, alu_a=0, alu_b=0.
- On a grant clock edge:
  - rsp_out/rsp_c/rsp_z <= alu_out/alu_c/alu_z; rsp_id <= winner; rsp_valid <= 1; last_grant <= winner; state -> FULL.
- Drain without a new grant: when rsp_valid & rsp_ready and no grant, rsp_valid <= 0 and state -> EMPTY. Data fields hold their last value.
- Simultaneous drain and grant: the new response replaces the old in the same edge; rsp_valid stays 1. This gives 1 result/cycle sustained.
- Backpressure: FULL & !rsp_ready → all response fields stable, req_ready=0, last_grant unchanged.
- Latency: request accepted in cycle N → rsp_valid in cycle N+1.
- Requester rule: req_valid and its fields stay stable until req_ready is seen. The arbiter does not check this.
- Fairness: a continuously requesting port waits at most NREQ-1 grants.
- Single requester active: granted every issuable cycle.
- Reset mid-operation: a pending response is discarded (rsp_valid=0 next cycle); pointer returns to NREQ-1.
- Flags are passed through unmodified; no reinterpretation of c/z per opcode.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - stat_grants[8i+7:8i] increments on each grant to requester i and saturates at 255.
  - Cleared only by rst.
- Undefined: no counter registers; stat_grants tied to 0. Port list is unchanged.

Test Plan:
- Single requester 0: op=000, a=3, b=1, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_out=0, rsp_c=1, rsp_z=1.
- All 4 requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,…; one response per cycle. With ALU_ARB_STATS_EN, each counter =2 after 8 cycles.
- Requester 2: op=001, a=1, b=2 with rsp_ready=0 for 3 cycles → rsp_out=3, rsp_c=1, rsp_z=0 held stable, req_ready=0 throughout. Accepting resumes the cycle rsp_ready=1.
- Requesters 1 and 3 valid, last_grant=1 → requester 3 granted first, then 1.
- rst asserted while FULL → next cycle rsp_valid=0 and all outputs at reset values. Next grant with requesters 0 and 1 valid goes to 0.
- ALU_ARB_STATS_EN: 300 consecutive grants to requester 1 → stat_grants[15:8]=255, other counters 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational 2-bit ALU slice between NREQ requesters.
//   Requesters are picked round-robin. The winner's operation is driven to the ALU.
//   The ALU result is captured into one registered response channel, tagged
//   with the owner's index.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (req_ready is one-hot or 0)
//   req_op/req_a/req_b       packed per-requester fields (3/2/2 bits each)
//   alu_op/alu_a/alu_b       operands to the shared ALU (zero when idle)
//   alu_out/alu_c/alu_z      combinational ALU result
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/rsp_out/rsp_c/rsp_z  captured response
//   stat_grants              8-bit saturating grant counter per requester
//
// Optional build macro: ALU_ARB_STATS_EN enables the grant counters.
//   Without it, stat_grants is tied to zero.
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [3*NREQ-1:0]   req_op,
  input  logic [2*NREQ-1:0]   req_a,
  input  logic [2*NREQ-1:0]   req_b,
  output logic [2:0]          alu_op,
  output logic [1:0]          alu_a,
  output logic [1:0]          alu_b,
  input  logic [1:0]          alu_out,
  input  logic                alu_c,
  input  logic                alu_z,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [1:0]          rsp_out,
  output logic                rsp_c,
  output logic                rsp_z,
  output logic [8*NREQ-1:0]   stat_grants
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic           can_issue;
  logic           gnt;
  logic [IDW-1:0] win;

  // Round-robin pick: each valid requester has a distance from the slot just
  // after last_grant. The smallest distance wins. A drain in the same cycle
  // frees the register, so a new grant can land in the same edge.
  always_comb begin
    int d;
    int best_d;
    d         = 0;
    best_d    = NREQ;
    gnt       = 1'b0;
    win       = '0;
    can_issue = (state == EMPTY) | (rsp_valid & rsp_ready);
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - 1 - int'(last_grant)) % NREQ;
      if (req_valid[i] && d < best_d) begin
        best_d = d;
        gnt    = 1'b1;
        win    = IDW'(i);
      end
    end
    if (!can_issue) gnt = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    alu_op    = 3'b000;
    alu_a     = 2'b00;
    alu_b     = 2'b00;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt && win == IDW'(i)) begin
        req_ready[i] = 1'b1;
        alu_op       = req_op[3*i +: 3];
        alu_a        = req_a[2*i +: 2];
        alu_b        = req_b[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_out    <= 2'b00;
      rsp_c      <= 1'b0;
      rsp_z      <= 1'b0;
      last_grant <= IDW'(NREQ - 1);
    end else if (gnt) begin
      state      <= FULL;
      rsp_valid  <= 1'b1;
      rsp_id     <= win;
      rsp_out    <= alu_out;
      rsp_c      <= alu_c;
      rsp_z      <= alu_z;
      last_grant <= win;
    end else if (rsp_valid && rsp_ready) begin
      // Data fields intentionally hold their last value after a drain.
      state     <= EMPTY;
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [NREQ-1:0][7:0] cnt;

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    always_ff @(posedge clk) begin
      if (rst)
        cnt[g] <= 8'd0;
      else if (gnt && win == IDW'(g) && cnt[g] != 8'hff)
        cnt[g] <= cnt[g] + 8'd1;
    end
  end

  assign stat_grants = cnt;
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [2*NREQ-1:0] req_a;
  logic [2*NREQ-1:0] req_b;
  logic [2:0]        alu_op;
  logic [1:0]        alu_a;
  logic [1:0]        alu_b;
  logic [1:0]        alu_out;
  logic              alu_c;
  logic              alu_z;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [1:0]        rsp_out;
  logic              rsp_c;
  logic              rsp_z;
  logic [8*NREQ-1:0] stat_grants;

  int compared   = 0;
  int mismatched = 0;

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_c(rsp_c), .rsp_z(rsp_z),
    .stat_grants(stat_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench ALU slice: add, sub, and, or, xor, not-a. Returns {c, z, out}.
  function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
    logic [2:0] r;
    case (op)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      default: r = {1'b0, ~a};
    endcase
    return {r[2], r[1:0] == 2'b00, r[1:0]};
  endfunction

  always_comb {alu_c, alu_z, alu_out} = alu_f(alu_op, alu_a, alu_b);

  // Reference model state
  bit   known = 1'b0;
  int   m_ptr;
  bit   m_full;
  int   m_id;
  logic [1:0] m_out;
  bit   m_c, m_z;
  int   m_cnt[NREQ];

  function automatic logic [2:0] f_op(input int j); return 3'(req_op >> (3*j)); endfunction
  function automatic logic [1:0] f_a(input int j);  return 2'(req_a >> (2*j));  endfunction
  function automatic logic [1:0] f_b(input int j);  return 2'(req_b >> (2*j));  endfunction

  // Winner: walk the ring starting just after the last grant; -1 means no grant.
  function automatic int mwin();
    int j;
    if (m_full && !rsp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + 1 + k) % NREQ;
      if (((req_valid >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int w;
    logic [NREQ-1:0]   e_rdy;
    logic [8*NREQ-1:0] e_stat;
    if (!known) return;
    w      = mwin();
    e_rdy  = (w >= 0) ? NREQ'(1 << w) : '0;
    e_stat = '0;
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) e_stat |= (8*NREQ)'(m_cnt[i]) << (8*i);
`endif
    check("m_req_ready", 64'(req_ready), 64'(e_rdy));
    check("m_alu_op", 64'(alu_op), (w >= 0) ? 64'(f_op(w)) : 64'd0);
    check("m_alu_a",  64'(alu_a),  (w >= 0) ? 64'(f_a(w))  : 64'd0);
    check("m_alu_b",  64'(alu_b),  (w >= 0) ? 64'(f_b(w))  : 64'd0);
    check("m_rsp_valid", 64'(rsp_valid), 64'(m_full));
    check("m_rsp_id",  64'(rsp_id),  64'(m_id));
    check("m_rsp_out", 64'(rsp_out), 64'(m_out));
    check("m_rsp_c",   64'(rsp_c),   64'(m_c));
    check("m_rsp_z",   64'(rsp_z),   64'(m_z));
    check("m_stat",    64'(stat_grants), 64'(e_stat));
  endtask

  task automatic model_update();
    int w;
    logic [3:0] r;
    if (rst) begin
      known = 1'b1; m_ptr = NREQ - 1; m_full = 1'b0; m_id = 0;
      m_out = 2'b00; m_c = 1'b0; m_z = 1'b0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      return;
    end
    w = mwin();
    if (w >= 0) begin
      r = alu_f(f_op(w), f_a(w), f_b(w));
      m_full = 1'b1; m_id = w; m_ptr = w;
      m_c = r[3]; m_z = r[2]; m_out = r[1:0];
      if (m_cnt[w] < 255) m_cnt[w]++;
    end else if (m_full && rsp_ready) begin
      m_full = 1'b0;
    end
  endtask

  // One clock: check settled outputs, take the edge, advance the model, stop at negedge.
  task automatic cycle();
    #1;
    compare_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
    req_op = (req_op & ~(12'h7 << (3*i))) | (12'(op) << (3*i));
    req_a  = (req_a  & ~(8'h3  << (2*i))) | (8'(a)   << (2*i));
    req_b  = (req_b  & ~(8'h3  << (2*i))) | (8'(b)   << (2*i));
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    @(negedge clk);
    cycle();
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_id",    64'(rsp_id),    64'd0);
    check("rst_out",   64'(rsp_out),   64'd0);
    check("rst_stat",  64'(stat_grants), 64'd0);
    rst = 1'b0;

    // Single requester 0: 3+1 -> out 0, carry, zero
    set_req(0, 3'd0, 2'd3, 2'd1); req_valid = 4'b0001; rsp_ready = 1'b1;
    #1 check("t1_ready", 64'(req_ready), 64'h1);
    cycle();
    req_valid = '0;
    check("t1_valid", 64'(rsp_valid), 64'd1);
    check("t1_id",    64'(rsp_id),    64'd0);
    check("t1_out",   64'(rsp_out),   64'd0);
    check("t1_c",     64'(rsp_c),     64'd1);
    check("t1_z",     64'(rsp_z),     64'd1);

    // All requesters continuously valid: strict rotation from 0
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 2'(i), 2'(3 - i));
    req_valid = 4'hf;
    for (int n = 0; n < 8; n++) begin
      cycle();
      check("t2_order", 64'(rsp_id), 64'(n % 4));
      check("t2_valid", 64'(rsp_valid), 64'd1);
    end
`ifdef ALU_ARB_STATS_EN
    check("t2_stat", 64'(stat_grants), 64'h02020202);
`endif

    // Backpressure: requester 2 computes 1-2 -> 3 with borrow, held 3 cycles
    req_valid = '0; cycle();
    set_req(2, 3'd1, 2'd1, 2'd2); req_valid = 4'b0100; rsp_ready = 1'b0;
    cycle();
    set_req(0, 3'd2, 2'd3, 2'd3); req_valid = 4'b0001;
    for (int n = 0; n < 3; n++) begin
      #1;
      check("t3_stall_ready", 64'(req_ready), 64'd0);
      check("t3_out", 64'(rsp_out), 64'd3);
      check("t3_c",   64'(rsp_c),   64'd1);
      check("t3_z",   64'(rsp_z),   64'd0);
      check("t3_id",  64'(rsp_id),  64'd2);
      cycle();
    end
    rsp_ready = 1'b1;
    #1 check("t3_resume_ready", 64'(req_ready), 64'h1);
    cycle();
    check("t3_next_id",  64'(rsp_id),  64'd0);
    check("t3_next_out", 64'(rsp_out), 64'd3);

    // last_grant = 1, then 1 and 3 compete: 3 first, then 1
    set_req(1, 3'd4, 2'd2, 2'd1); req_valid = 4'b0010;
    cycle();
    check("t4_setup_id", 64'(rsp_id), 64'd1);
    set_req(3, 3'd5, 2'd1, 2'd0); req_valid = 4'b1010;
    cycle();
    check("t4_first",  64'(rsp_id),  64'd3);
    check("t4_out3",   64'(rsp_out), 64'd2);
    cycle();
    check("t4_second", 64'(rsp_id),  64'd1);

    // Reset while FULL discards the response and restores priority to 0
    rst = 1'b1; set_req(0, 3'd0, 2'd1, 2'd1); req_valid = 4'b0011;
    cycle();
    check("t5_valid", 64'(rsp_valid), 64'd0);
    check("t5_id",    64'(rsp_id),    64'd0);
    check("t5_out",   64'(rsp_out),   64'd0);
    check("t5_stat",  64'(stat_grants), 64'd0);
    rst = 1'b0;
    cycle();
    check("t5_grant_id", 64'(rsp_id),  64'd0);
    check("t5_grant_out", 64'(rsp_out), 64'd2);

    // 300 grants to requester 1: counter saturates
    rst = 1'b1; cycle(); rst = 1'b0;
    set_req(1, 3'd0, 2'd0, 2'd0); req_valid = 4'b0010;
    for (int n = 0; n < 300; n++) cycle();
`ifdef ALU_ARB_STATS_EN
    check("t6_stat", 64'(stat_grants), 64'h0000ff00);
`else
    check("t6_stat", 64'(stat_grants), 64'd0);
`endif
    check("t6_id", 64'(rsp_id), 64'd1);
    req_valid = '0;
    cycle();
    check("t6_drain", 64'(rsp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
